// File: rtl/mdu_if.sv
// Handshake and data bundle between a requester and the iterative multiply/divide unit.
// The master side drives requests and MTHI/MTLO writes; the slave side returns status and HI/LO.
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Each operation takes a fixed 34 cycles: 32 bit-serial steps followed by 2 sign-fixup cycles.
module mdu_iter (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        bzero_q, bzero_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        in_signed_s;
    logic        in_div_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_sh_s;
    logic        div_ge_s;
    logic [31:0] div_rem_s;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign in_signed_s = ~bus.op[0];
    assign in_div_s    = bus.op[1];
    assign abs_a_s     = cond_neg32(bus.a, in_signed_s & bus.a[31]);
    assign abs_b_s     = cond_neg32(bus.b, in_signed_s & bus.b[31]);

    // Multiply step: conditionally add multiplicand to the upper half, then shift the 64-bit accumulator right.
    assign mul_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Restoring divide step: shift the next dividend bit into the partial remainder and try the subtraction.
    assign div_sh_s  = {acc_q[63:32], acc_q[31]};
    assign div_ge_s  = (div_sh_s >= {1'b0, opnd_q});
    assign div_rem_s = div_ge_s ? (div_sh_s[31:0] - opnd_q) : div_sh_s[31:0];

    // Next-state, datapath and result-register update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        bzero_d  = bzero_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    cnt_d    = 6'd0;
                    div_d    = in_div_s;
                    a_raw_d  = bus.a;
                    bzero_d  = (bus.b == 32'd0);
                    neg_lo_d = in_signed_s & (bus.a[31] ^ bus.b[31]);
                    neg_hi_d = in_div_s ? (in_signed_s & bus.a[31])
                                        : (in_signed_s & (bus.a[31] ^ bus.b[31]));
                    if (in_div_s) begin
                        acc_d  = {32'd0, abs_a_s};
                        opnd_d = abs_b_s;
                    end else begin
                        acc_d  = {32'd0, abs_b_s};
                        opnd_d = abs_a_s;
                    end
                end else begin
                    if (bus.hi_we) begin
                        hi_d = bus.wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.lo_we) begin
                        lo_d = bus.wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            CALC: begin
                if (div_q) begin
                    acc_d = {div_rem_s, acc_q[30:0], div_ge_s};
                end else begin
                    acc_d = {mul_sum_s, acc_q[31:1]};
                end
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            FIX: begin
                // First FIX cycle corrects signs in place; second publishes the result.
                if (cnt_q == 6'd0) begin
                    cnt_d = 6'd1;
                    if (!div_q) begin
                        acc_d = cond_neg64(acc_q, neg_lo_q);
                    end else if (bzero_q) begin
                        acc_d = {a_raw_q, 32'hFFFF_FFFF};
                    end else begin
                        acc_d = {cond_neg32(acc_q[63:32], neg_hi_q),
                                 cond_neg32(acc_q[31:0], neg_lo_q)};
                    end
                end else begin
                    hi_d    = acc_q[63:32];
                    lo_d    = acc_q[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            a_raw_q  <= 32'd0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed operations push expected HI/LO and done cycle,
// a monitor pops and compares on every done pulse.
module tb_mdu_iter;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    int   done_cnt;
    exp_t sb[$];

    mdu_if bus ();

    mdu_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input string nm);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (push) sb.push_back('{hi: eh, lo: el, cyc: cyc + 34, name: nm});
    endtask

    task automatic wait_sb(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: done not seen within %0d cycles", sb[0].name, bound);
            sb.delete();
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard.
    initial begin
        exp_t e;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done at cycle %0d with nothing expected", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
                    check({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
                    check({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, "_busy"}, {63'd0, bus.busy}, 64'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hi",   {32'd0, bus.hi},   64'd0);
        check("rst_lo",   {32'd0, bus.lo},   64'd0);

        // MTHI in IDLE
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'hDEAD_BEEF});
        check("mthi_lo", {32'd0, bus.lo}, 64'd0);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        check("busy_calc", {63'd0, bus.busy}, 64'd1);
        wait_sb(60);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        wait_sb(60);
        issue(2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 1'b1, 32'h0000_0000, 32'd24, "mult_m4xm6");
        wait_sb(60);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
        wait_sb(60);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2");
        wait_sb(60);
        issue(2'b11, 32'd100, 32'd0, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
        wait_sb(60);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7by0");
        wait_sb(60);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        wait_sb(60);

        // Start and lo_we while busy are ignored; operand changes have no effect.
        d0 = done_cnt;
        issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, "divu_100d7");
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        bus.a     = 32'h5555_AAAA;
        bus.b     = 32'h0000_0003;
        check("lo_we_busy", {32'd0, bus.lo}, {32'd0, 32'h8000_0000});
        wait_sb(60);
        repeat (40) @(posedge clk);
        #1;
        check("single_done", 64'(done_cnt), 64'(d0 + 1));

        // start and lo_we in the same IDLE cycle: write dropped.
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        issue(2'b01, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, "multu_6x7");
        bus.lo_we = 1'b0;
        check("start_wins_lo", {32'd0, bus.lo}, 64'd14);
        wait_sb(60);

        // Reset mid-operation aborts without a done pulse.
        issue(2'b10, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, "div_abort");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hi",   {32'd0, bus.hi},   64'd0);
        check("abort_lo",   {32'd0, bus.lo},   64'd0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        issue(2'b01, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, "multu_after_rst");
        wait_sb(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
